// File: rtl/set_scheduler.sv
// set_scheduler: round-robin two-requester job scheduler driving the SET datapath, with a result timeout
module set_scheduler #(
  parameter int TIMEOUT = 200,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [23:0] req0_central,
  input  logic [23:0] req1_central,
  input  logic [11:0] req0_radius,
  input  logic [11:0] req1_radius,
  input  logic [1:0]  req0_mode,
  input  logic [1:0]  req1_mode,
  output logic        set_en,
  output logic [23:0] set_central,
  output logic [11:0] set_radius,
  output logic [1:0]  set_mode,
  input  logic        set_busy,
  input  logic        set_valid,
  input  logic [7:0]  set_candidate,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [7:0]  res_candidate,
  output logic        res_err,
  output logic        sched_busy
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  state_t      state_q, state_d;
  logic        last_q, last_d, id_q, id_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0] central_q, central_d;
  logic [11:0] radius_q, radius_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  cand_q, cand_d;
  logic        gnt, accept;
  // Round-robin pick and the single-cycle accept window (IDLE, SET idle, not in reset)
  always_comb begin
    gnt       = (&req_valid) ? ~last_q : req_valid[1];
    accept    = rst_n & (state_q == IDLE) & ~set_busy & (|req_valid);
    req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  end
  // Next-state logic: latch operands on accept, time the SET wait, capture the result
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    central_d = central_q;
    radius_d  = radius_q;
    mode_d    = mode_q;
    cand_d    = cand_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d   = LAUNCH;
        last_d    = gnt;
        id_d      = gnt;
        central_d = gnt ? req1_central : req0_central;
        radius_d  = gnt ? req1_radius : req0_radius;
        mode_d    = gnt ? req1_mode : req0_mode;
      end
      LAUNCH: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (set_valid) begin
        state_d = RESP;
        cand_d  = set_candidate;
        err_d   = 1'b0;
      end else if (cnt_q == LAST) begin
        state_d = RESP;
        cand_d  = '0;
        err_d   = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      RESP: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers; reset clears everything and favours requester 0 next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      cnt_q     <= '0;
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      cand_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      central_q <= central_d;
      radius_q  <= radius_d;
      mode_q    <= mode_d;
      cand_q    <= cand_d;
      err_q     <= err_d;
    end
  end
  assign set_en        = state_q == LAUNCH;
  assign res_valid     = state_q == RESP;
  assign sched_busy    = state_q != IDLE;
  assign set_central   = central_q;
  assign set_radius    = radius_q;
  assign set_mode      = mode_q;
  assign res_id        = id_q;
  assign res_candidate = cand_q;
  assign res_err       = err_q;
endmodule

// File: tb/tb_set_scheduler.sv
// tb_set_scheduler: directed stimulus with a cycle-timeline reference model for set_scheduler
module tb_set_scheduler;
  localparam int TO = 200;
  logic        clk = 0, rst_n = 0;
  logic [1:0]  req_valid = 0, req_ready;
  logic [23:0] req0_central = 0, req1_central = 0, set_central;
  logic [11:0] req0_radius = 0, req1_radius = 0, set_radius;
  logic [1:0]  req0_mode = 0, req1_mode = 0, set_mode;
  logic        set_en, set_busy = 0, set_valid = 0, res_valid, res_ready = 0, res_id, res_err, sched_busy;
  logic [7:0]  set_candidate = 0, res_candidate;
  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  set_scheduler #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_central(req0_central), .req1_central(req1_central),
    .req0_radius(req0_radius), .req1_radius(req1_radius),
    .req0_mode(req0_mode), .req1_mode(req1_mode),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
    .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_candidate(res_candidate), .res_err(res_err), .sched_busy(sched_busy)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SET stand-in: answers set_delay WAIT cycles after the launch pulse (-1 = never)
  int set_delay = 0, k = -1;
  bit use_fixed = 1, en_seen = 0;
  logic [7:0] fixed_val = 0;
  always begin
    @(negedge clk);
    en_seen = set_en;
    @(posedge clk);
    #1;
    set_valid = 0;
    if (!rst_n) k = -1;
    else if (en_seen) k = 0;
    else if (k >= 0) k++;
    if (k >= 0 && k == set_delay) begin
      set_valid = 1;
      set_candidate = use_fixed ? fixed_val : set_central[7:0] + 8'(set_mode);
      k = -1;
    end
  end

  // Reference model: a job is tracked by its age in cycles since accept
  bit m_busy = 0, m_done = 0, m_err = 0, m_last = 1, m_id = 0, mg;
  int m_age = 0;
  logic [7:0]  m_cand;
  logic [23:0] m_c;
  logic [11:0] m_r;
  logic [1:0]  m_m, mer;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_last = 1;
      chk("rst_ctl", {req_ready, set_en, res_valid, sched_busy, res_id, res_err, res_candidate}, 0);
      chk("rst_ops", {set_central, set_radius, set_mode}, 0);
    end else begin
      mg  = (&req_valid) ? !m_last : req_valid[1];
      mer = (!m_busy && !set_busy && |req_valid) ? (mg ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", req_ready, mer);
      chk("set_en", set_en, m_busy && m_age == 1);
      chk("res_valid", res_valid, m_busy && m_done);
      chk("sched_busy", sched_busy, m_busy);
      if (m_busy && !m_done) chk("set_ops", {set_central, set_radius, set_mode}, {m_c, m_r, m_m});
      if (m_busy && m_done) chk("res", {res_id, res_err, res_candidate}, {m_id, m_err, m_cand});
      if (mer != 0) begin
        m_busy = 1; m_done = 0; m_age = 1; m_id = mg; m_last = mg;
        m_c = mg ? req1_central : req0_central;
        m_r = mg ? req1_radius : req0_radius;
        m_m = mg ? req1_mode : req0_mode;
      end else if (m_busy && !m_done) begin
        if (m_age >= 2 && set_valid) begin m_done = 1; m_err = 0; m_cand = set_candidate; end
        else if (m_age - 2 == TO - 1) begin m_done = 1; m_err = 1; m_cand = 0; end
        m_age++;
      end else if (m_busy && m_done && res_ready) m_busy = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output logic [1:0] who, output int c);
    int n = 0;
    who = 0;
    c = 0;
    while (who == 0 && n < 50) begin
      @(negedge clk);
      who = req_valid & req_ready;
      c = cyc;
      n++;
      step();
    end
    chk("accept_seen", who != 0, 1);
    @(negedge clk);
    chk("en_after_accept", set_en, 1);
    step();
  endtask

  task automatic wait_res(output int rc);
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    rc = cyc;
    chk("res_seen", res_valid, 1);
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  logic [1:0] who;
  int c, r;
  logic [1:0] exp_order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  initial begin
    repeat (3) step();
    rst_n = 1;
    // single job on requester 0, SET answers 29 in the first WAIT cycle
    req0_central = 24'h444444; req0_radius = 12'h333; req0_mode = 0;
    use_fixed = 1; fixed_val = 8'd29; set_delay = 0;
    req_valid = 2'b01;
    wait_accept(who, c);
    req_valid = 0;
    chk("t1_grant", who, 2'b01);
    wait_res(r);
    chk("t1_lat", r - c, 3);
    chk("t1_res", {res_id, res_err, res_candidate}, {1'b0, 1'b0, 8'd29});
    step();
    res_ready = 1;
    step();
    res_ready = 0;
    // both requesters held valid: alternating grants starting with 0
    pulse_reset();
    req0_central = 24'h123456; req0_radius = 12'hABC; req0_mode = 2;
    req1_central = 24'h89ABCD; req1_radius = 12'h5A5; req1_mode = 3;
    use_fixed = 0; set_delay = 1; res_ready = 1; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_accept(who, c);
      chk("t2_order", who, exp_order[i]);
    end
    req_valid = 0;
    repeat (5) step();
    // SET never answers: timeout after TO WAIT cycles, then result stalled 10 cycles
    set_delay = -1; res_ready = 0; req_valid = 2'b10;
    wait_accept(who, c);
    req_valid = 0;
    wait_res(r);
    chk("t3_lat", r - (c + 2), TO);
    chk("t3_res", {res_id, res_err, res_candidate}, {1'b1, 1'b1, 8'd0});
    for (int i = 0; i < 10; i++) begin
      step();
      req_valid = 2'b11;
      @(negedge clk);
      chk("t4_hold", {res_valid, res_id, res_err, res_candidate}, {1'b1, 1'b1, 1'b1, 8'd0});
      chk("t4_quiet", {req_ready, set_en}, 0);
    end
    step();
    res_ready = 1; req_valid = 0;
    step();
    res_ready = 0;
    // set_valid arrives in the very cycle the timeout would fire
    use_fixed = 1; fixed_val = 8'hA5; set_delay = TO - 1; req_valid = 2'b01;
    wait_accept(who, c);
    req_valid = 0;
    wait_res(r);
    chk("t5_lat", r - (c + 2), TO);
    chk("t5_res", {res_id, res_err, res_candidate}, {1'b0, 1'b0, 8'hA5});
    step();
    res_ready = 1;
    step();
    res_ready = 0;
    // reset during WAIT, then grant held off while SET busy, then requester 0 first
    set_delay = -1; req_valid = 2'b10;
    wait_accept(who, c);
    req_valid = 0;
    repeat (3) step();
    req_valid = 2'b11;
    rst_n = 0;
    #1;
    chk("t6_rst_ctl", {req_ready, set_en, res_valid, sched_busy, res_id, res_err, res_candidate}, 0);
    chk("t6_rst_ops", {set_central, set_radius, set_mode}, 0);
    step();
    step();
    rst_n = 1; set_busy = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_busy_hold", req_ready, 0);
      step();
    end
    set_busy = 0;
    wait_accept(who, c);
    req_valid = 0;
    chk("t6_first_grant", who, 2'b01);
    set_delay = 2; res_ready = 1;
    wait_res(r);
    chk("t6_res", {res_id, res_err}, 0);
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1);
  end
endmodule
